// File: rtl/bcd_counter8.sv
// Eight-digit BCD up/down counter with prescaler; feeds the seven-segment display stage.
// Digits, tick and wrap are registered; carry/borrow ripples through all digits in one cycle.

module bcd_digit (
  input  logic [3:0] d_i,
  input  logic       up_i,
  input  logic       c_i,
  output logic [3:0] d_o,
  output logic       c_o
);
  always_comb begin
    d_o = d_i;
    c_o = 1'b0;
    if (c_i) begin
      if (up_i) begin
        if (d_i >= 4'd9) begin
          d_o = 4'd0;
          c_o = 1'b1;
        end else begin
          d_o = d_i + 4'd1;
        end
      end else begin
        if (d_i == 4'd0) begin
          d_o = 4'd9;
          c_o = 1'b1;
        end else begin
          d_o = d_i - 4'd1;
        end
      end
    end
  end
endmodule

module bcd_counter8 #(
  parameter int NDIG     = 8,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       up,
  input  logic       clear,
  output logic [3:0] digits [0:NDIG-1],
  output logic       tick,
  output logic       wrap
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] p_q, p_d;
  logic [3:0]    dig_q [0:NDIG-1];
  logic [3:0]    dig_d [0:NDIG-1];
  logic [3:0]    nxt   [0:NDIG-1];
  logic [NDIG:0] cy;
  logic          tick_q, tick_d, wrap_q, wrap_d;
  logic          step;

  // Digit 0 always receives the step; cy[NDIG] out of the top digit is the wrap.
  assign cy[0] = 1'b1;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit u_dig (
      .d_i  (dig_q[g]),
      .up_i (up),
      .c_i  (cy[g]),
      .d_o  (nxt[g]),
      .c_o  (cy[g+1])
    );
  end

  always_comb begin
    step   = enable && !clear && (p_q == PMAX);
    p_d    = p_q;
    dig_d  = dig_q;
    tick_d = step;
    wrap_d = step && cy[NDIG];
    if (clear) begin
      p_d = '0;
      for (int i = 0; i < NDIG; i++) dig_d[i] = 4'd0;
    end else if (step) begin
      p_d   = '0;
      dig_d = nxt;
    end else if (enable) begin
      p_d = p_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_q    <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      for (int i = 0; i < NDIG; i++) dig_q[i] <= 4'd0;
    end else begin
      p_q    <= p_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      dig_q  <= dig_d;
    end
  end

  assign digits = dig_q;
  assign tick   = tick_q;
  assign wrap   = wrap_q;
endmodule
